// File: rtl/img_bus_pkg.sv
// Shared definitions for the image controller bus responder:
// FSM state encoding, default bus widths and frame store depth.
package img_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ACK   = 2'd2,
    RECOV = 2'd3
  } resp_state_e;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 16;
  localparam int COL_MAX     = 600;
  localparam int ROW_MAX     = 400;
  localparam int FRAME_DEPTH = COL_MAX * ROW_MAX / 4;

endpackage

// File: rtl/img_mem_sp.sv
// Single-port synchronous word store for packed pixels (4 x 8 bit per word).
// Out-of-range writes are dropped and out-of-range reads return zero.
module img_mem_sp
  import img_bus_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = FRAME_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;

  assign in_range = ({1'b0, addr} < DEPTH_EXT);

  // The array itself is never reset so frame contents survive rst.
  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= in_range ? mem[addr] : '0;
    end
  end

endmodule

// File: rtl/img_mem_resp.sv
// Bus responder for the image controller: wait-state FSM, one-cycle ack,
// out-of-range error flag and read/write transaction counters.
module img_mem_resp
  import img_bus_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DEPTH    = FRAME_DEPTH,
  parameter int WAIT_CYC = 2,
  parameter int CNT_W    = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_cs_n_i,
  input  logic              bus_we_i,
  input  logic [ADDR_W-1:0] bus_addr_i,
  input  logic [DATA_W-1:0] bus_wdata_i,
  output logic [DATA_W-1:0] bus_rdata_o,
  output logic              bus_ack_o,
  output logic              bus_err_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  rd_cnt_o,
  output logic [CNT_W-1:0]  wr_cnt_o
);

  localparam int              WCNT_W    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  resp_state_e       state_q, state_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_d;
  logic              go_ack;

  logic              eff_we;
  logic [ADDR_W-1:0] eff_addr;
  logic [DATA_W-1:0] eff_wdata;
  logic              in_range;

  // With zero wait states the access completes on the accepting edge, so
  // the live bus inputs stand in for the not-yet-latched request.
  assign eff_we    = (state_q == IDLE) ? bus_we_i    : we_q;
  assign eff_addr  = (state_q == IDLE) ? bus_addr_i  : addr_q;
  assign eff_wdata = (state_q == IDLE) ? bus_wdata_i : wdata_q;
  assign in_range  = ({1'b0, eff_addr} < DEPTH_EXT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_o;
    go_ack  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus_cs_n_i) begin
          we_d    = bus_we_i;
          addr_d  = bus_addr_i;
          wdata_d = bus_wdata_i;
          busy_d  = 1'b1;
          if (WAIT_CYC > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            go_ack = 1'b1;
          end
        end
      end
      WAIT: begin
        if (bus_cs_n_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == '0) begin
          go_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - WCNT_W'(1);
        end
      end
      ACK: begin
        state_d = RECOV;
      end
      RECOV: begin
        if (bus_cs_n_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
    if (go_ack) begin
      state_d = ACK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      busy_o    <= 1'b0;
      bus_ack_o <= 1'b0;
      bus_err_o <= 1'b0;
      rd_cnt_o  <= '0;
      wr_cnt_o  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      busy_o    <= busy_d;
      bus_ack_o <= go_ack;
      bus_err_o <= go_ack && !in_range;
      if (go_ack && eff_we) begin
        wr_cnt_o <= wr_cnt_o + CNT_W'(1);
      end
      if (go_ack && !eff_we) begin
        rd_cnt_o <= rd_cnt_o + CNT_W'(1);
      end
    end
  end

  img_mem_sp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (go_ack && eff_we && in_range),
    .re   (go_ack && !eff_we),
    .addr (eff_addr),
    .wdata(eff_wdata),
    .rdata(bus_rdata_o)
  );

endmodule
